// File: rtl/lmsm_sequencer.sv
// Load-Multiple / Store-Multiple sequencer: walks an 8-bit register mask from R0 upward,
// moving one word per selected register between the register file and consecutive memory addresses.
module lmsm_sequencer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_store,
  input  logic [7:0]        mask,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DATA_W-1:0] reg_rdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [2:0]        reg_addr,
  output logic              reg_we,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_XFER, S_WB, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [7:0]        pend_q, pend_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        idx_q, idx_d;
  logic [DATA_W-1:0] wbuf_q, wbuf_d;
  logic              st_q, st_d;
  logic [2:0]        low_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      addr_q  <= '0;
      idx_q   <= '0;
      wbuf_q  <= '0;
      st_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      wbuf_q  <= wbuf_d;
      st_q    <= st_d;
    end
  end

  // Descending scan so the lowest set bit is the last (winning) assignment.
  always_comb begin
    low_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pend_q[i]) low_idx = 3'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    wbuf_d  = wbuf_q;
    st_d    = st_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pend_d  = mask;
          addr_d  = base_addr;
          st_d    = is_store;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (pend_q == 8'd0) begin
          state_d = S_DONE;
        end else begin
          idx_d   = low_idx;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        if (mem_ready) begin
          if (st_q) begin
            pend_d[idx_q] = 1'b0;
            addr_d        = addr_q + ADDR_W'(1);
            state_d       = S_SCAN;
          end else begin
            wbuf_d  = mem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        pend_d[idx_q] = 1'b0;
        addr_d        = addr_q + ADDR_W'(1);
        state_d       = S_SCAN;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs; only mem_wdata passes reg_rdata through during a store request.
  always_comb begin
    reg_addr  = 3'd0;
    reg_we    = 1'b0;
    reg_wdata = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    case (state_q)
      S_XFER: begin
        mem_req   = 1'b1;
        mem_we    = st_q;
        mem_addr  = addr_q;
        reg_addr  = idx_q;
        mem_wdata = st_q ? reg_rdata : '0;
      end
      S_WB: begin
        reg_we    = 1'b1;
        reg_addr  = idx_q;
        reg_wdata = wbuf_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Bench for lmsm_sequencer: register file and memory models around the DUT, directed scenarios
// plus randomized operations checked against a mask-walking reference model.
module tb_lmsm_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [7:0]  mask = 8'd0;
  logic [15:0] base_addr = 16'd0;
  logic [15:0] reg_rdata, mem_rdata;
  logic        mem_ready = 1'b0;
  logic [2:0]  reg_addr;
  logic        reg_we;
  logic [15:0] reg_wdata;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic        busy, done;

  logic [15:0] regs [0:7];
  logic [15:0] mem  [0:65535];

  assign reg_rdata = regs[reg_addr];
  assign mem_rdata = mem[mem_addr];

  always #5 clk = ~clk;

  lmsm_sequencer #(.DATA_W(16), .ADDR_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store), .mask(mask),
    .base_addr(base_addr), .reg_rdata(reg_rdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .reg_addr(reg_addr), .reg_we(reg_we), .reg_wdata(reg_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done)
  );

  typedef struct packed {logic [15:0] a; logic [15:0] d;} xfer_t;

  int checks = 0;
  int errors = 0;

  // Observations of the most recent operation
  xfer_t       mw_q[$];
  xfer_t       rw_q[$];
  logic [15:0] mr_q[$];
  logic [2:0]  ra_q[$];
  int done_cyc, done_cnt, busy_first, req_cycles, waits, hold_viol;
  logic busy_after, busy_later;

  function automatic logic any_out();
    return busy | done | reg_we | mem_req | mem_we | (|reg_addr) | (|reg_wdata)
           | (|mem_addr) | (|mem_wdata);
  endfunction

  // mode 0: mem_ready high; 1: random; 2: low for the first 3 request cycles.
  // pulse: extra start strobes in cycle 3 and in the DONE cycle.
  task automatic run_op(input logic st, input logic [7:0] m, input logic [15:0] b,
                        input int mode, input bit pulse);
    int cyc = 0;
    bit prev_wait = 0;
    logic [15:0] pa = '0, pd = '0;
    logic pw = 1'b0;
    mw_q.delete(); rw_q.delete(); mr_q.delete(); ra_q.delete();
    done_cyc = -1; done_cnt = 0; busy_first = -1; req_cycles = 0; waits = 0; hold_viol = 0;
    busy_after = 1'b1; busy_later = 1'b1;
    @(negedge clk);
    is_store = st; mask = m; base_addr = b; start = 1'b1; mem_ready = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      case (mode)
        0:       mem_ready = 1'b1;
        1:       mem_ready = ($urandom_range(0, 9) < 6);
        default: mem_ready = !(mem_req && waits < 3);
      endcase
      if (busy && busy_first < 0) busy_first = cyc;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after = busy;
      if (done_cyc >= 0 && cyc == done_cyc + 2) busy_later = busy;
      if (mem_req) begin
        req_cycles++;
        if (prev_wait) begin
          if (mem_addr !== pa || mem_wdata !== pd || mem_we !== pw) hold_viol++;
        end else begin
          ra_q.push_back(reg_addr);
        end
        if (mem_ready) begin
          if (mem_we) begin
            mw_q.push_back({mem_addr, mem_wdata});
            mem[mem_addr] = mem_wdata;
          end else begin
            mr_q.push_back(mem_addr);
          end
        end else begin
          waits++;
        end
        prev_wait = !mem_ready;
        pa = mem_addr; pd = mem_wdata; pw = mem_we;
      end else begin
        prev_wait = 0;
      end
      if (reg_we) begin
        rw_q.push_back({13'd0, reg_addr, reg_wdata});
        regs[reg_addr] = reg_wdata;
      end
      // Scramble command inputs after the start strobe; latched values must not change.
      if (cyc == 1) begin
        start = 1'b0; is_store = 1'($urandom); mask = 8'($urandom); base_addr = 16'($urandom);
      end
      if (pulse && cyc == 3) begin
        start = 1'b1; is_store = 1'($urandom); mask = 8'($urandom) | 8'h01;
      end
      if (pulse && cyc == 4) start = 1'b0;
      if (pulse && done) start = 1'b1;
      if (pulse && done_cyc >= 0 && cyc == done_cyc + 1) start = 1'b0;
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      if (cyc >= 400) break;
    end
    checks++;
    if (done_cyc < 0) begin
      errors++;
      $display("FAIL op_timeout: got no done within %0d cycles, expected done", cyc);
    end
    mem_ready = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic seen = 1'b0;
    logic [15:0] r0;
    checks++;
    if (any_out() !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: got nonzero output, expected all 0");
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) regs[i] = 16'($urandom);
    @(negedge clk);
    is_store = 1'b1; mask = 8'hFF; base_addr = 16'h1234; start = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h1234 || mem_wdata !== regs[0]) begin
      errors++;
      $display("FAIL reset_pre_xfer: got req=%b addr=%h wdata=%h, expected 1 1234 %h",
               mem_req, mem_addr, mem_wdata, regs[0]);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (any_out() !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: got busy=%b req=%b addr=%h, expected all outputs 0",
               busy, mem_req, mem_addr);
    end
    mem_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      seen = seen | mem_req | reg_we | busy;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL reset_hold: got activity=%b, expected 0", seen);
    end
    reset = 1'b0;
    mem_ready = 1'b0;
    r0 = 16'($urandom);
    regs[0] = r0;
    run_op(1'b1, 8'h01, 16'h0200, 0, 1'b0);
    checks++;
    if (mw_q.size() != 1 || mw_q[0] !== {16'h0200, r0}) begin
      errors++;
      $display("FAIL reset_fresh_sm: got %0d writes, expected 1 write 0200<=%h", mw_q.size(), r0);
    end
    checks++;
    if (done_cyc != 4) begin
      errors++; $display("FAIL reset_fresh_done: got cycle %0d, expected 4", done_cyc);
    end
  endtask

  task automatic test_sm_directed();
    regs[0] = 16'h0008; regs[2] = 16'hC281; regs[7] = 16'h0002;
    run_op(1'b1, 8'b1000_0101, 16'h0040, 0, 1'b0);
    checks++;
    if (mw_q.size() != 3 || mw_q[0] !== {16'h0040, 16'h0008} || mw_q[1] !== {16'h0041, 16'hC281}
        || mw_q[2] !== {16'h0042, 16'h0002}) begin
      errors++;
      $display("FAIL sm_writes: got %0d writes first=%h, expected 3 writes 0040/0041/0042",
               mw_q.size(), (mw_q.size() > 0) ? mw_q[0] : 32'h0);
    end
    checks++;
    if (ra_q.size() != 3 || ra_q[0] !== 3'd0 || ra_q[1] !== 3'd2 || ra_q[2] !== 3'd7) begin
      errors++; $display("FAIL sm_reg_addr: got %0d entries, expected sequence 0,2,7", ra_q.size());
    end
    checks++;
    if (done_cyc != 8) begin
      errors++; $display("FAIL sm_done: got cycle %0d, expected 8", done_cyc);
    end
    checks++;
    if (rw_q.size() != 0) begin
      errors++; $display("FAIL sm_no_reg_we: got %0d reg writes, expected 0", rw_q.size());
    end
    checks++;
    if (busy_first != 1 || busy_after !== 1'b0) begin
      errors++;
      $display("FAIL sm_busy: got rise=%0d after_done=%b, expected 1 and 0", busy_first, busy_after);
    end
  endtask

  task automatic test_lm_directed();
    mem[16'h0010] = 16'hAAAA; mem[16'h0011] = 16'h5555;
    run_op(1'b0, 8'h0A, 16'h0010, 0, 1'b0);
    checks++;
    if (rw_q.size() != 2 || rw_q[0] !== {16'd1, 16'hAAAA} || rw_q[1] !== {16'd3, 16'h5555}) begin
      errors++;
      $display("FAIL lm_reg_writes: got %0d writes first=%h, expected R1<=AAAA R3<=5555",
               rw_q.size(), (rw_q.size() > 0) ? rw_q[0] : 32'h0);
    end
    checks++;
    if (mr_q.size() != 2 || mr_q[0] !== 16'h0010 || mr_q[1] !== 16'h0011) begin
      errors++; $display("FAIL lm_reads: got %0d reads, expected 0010 0011", mr_q.size());
    end
    checks++;
    if (done_cyc != 8) begin
      errors++; $display("FAIL lm_done: got cycle %0d, expected 8", done_cyc);
    end
    checks++;
    if (mw_q.size() != 0) begin
      errors++; $display("FAIL lm_no_mem_we: got %0d writes, expected 0", mw_q.size());
    end
  endtask

  task automatic test_wait_states();
    logic [15:0] r0 = 16'($urandom);
    regs[0] = r0;
    run_op(1'b1, 8'h01, 16'h0300, 2, 1'b0);
    checks++;
    if (req_cycles != 4 || hold_viol != 0) begin
      errors++;
      $display("FAIL wait_hold: got %0d req cycles %0d changes, expected 4 and 0", req_cycles, hold_viol);
    end
    checks++;
    if (mw_q.size() != 1 || mw_q[0] !== {16'h0300, r0}) begin
      errors++; $display("FAIL wait_write: got %0d writes, expected 1 write 0300<=%h", mw_q.size(), r0);
    end
    checks++;
    if (done_cyc != 7) begin
      errors++; $display("FAIL wait_done: got cycle %0d, expected 7", done_cyc);
    end
  endtask

  task automatic test_boundaries();
    logic [15:0] x = 16'($urandom), y = 16'($urandom), r1, r2;
    run_op(1'b1, 8'h00, 16'h0700, 0, 1'b0);
    checks++;
    if (done_cyc != 2 || req_cycles != 0) begin
      errors++;
      $display("FAIL zero_mask: got done=%0d reqs=%0d, expected 2 and 0", done_cyc, req_cycles);
    end
    mem[16'hFFFF] = x; mem[16'h0000] = y;
    run_op(1'b0, 8'hC0, 16'hFFFF, 0, 1'b0);
    checks++;
    if (rw_q.size() != 2 || rw_q[0] !== {16'd6, x} || rw_q[1] !== {16'd7, y}) begin
      errors++; $display("FAIL wrap_regs: got %0d writes, expected R6<=%h R7<=%h", rw_q.size(), x, y);
    end
    checks++;
    if (mr_q.size() != 2 || mr_q[0] !== 16'hFFFF || mr_q[1] !== 16'h0000) begin
      errors++; $display("FAIL wrap_addr: got %0d reads, expected FFFF 0000", mr_q.size());
    end
    r1 = 16'($urandom); r2 = 16'($urandom);
    regs[1] = r1; regs[2] = r2;
    run_op(1'b1, 8'h06, 16'h0500, 0, 1'b1);
    checks++;
    if (done_cnt != 1 || done_cyc != 6 || busy_after !== 1'b0 || busy_later !== 1'b0) begin
      errors++;
      $display("FAIL start_ignored: got done_cnt=%0d cyc=%0d busy=%b/%b, expected 1 6 0/0",
               done_cnt, done_cyc, busy_after, busy_later);
    end
    checks++;
    if (mw_q.size() != 2 || mw_q[0] !== {16'h0500, r1} || mw_q[1] !== {16'h0501, r2}) begin
      errors++; $display("FAIL start_ignored_writes: got %0d writes, expected 2", mw_q.size());
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 24; it++) begin
      xfer_t       exp_mw[$];
      xfer_t       exp_rw[$];
      logic [2:0]  exp_ra[$];
      logic        st = 1'($urandom);
      logic [7:0]  m = (it == 0) ? 8'hFF : 8'($urandom);
      logic [15:0] b = 16'($urandom);
      int k = 0, bad = 0, exp_done;
      for (int i = 0; i < 8; i++) regs[i] = 16'($urandom);
      for (int n = 0; n < 8; n++) mem[b + 16'(n)] = 16'($urandom);
      for (int i = 0; i < 8; i++) begin
        if (m[i]) begin
          logic [15:0] a = b + 16'(k);
          if (st) exp_mw.push_back({a, regs[i]});
          else    exp_rw.push_back({16'(i), mem[a]});
          exp_ra.push_back(3'(i));
          k++;
        end
      end
      run_op(st, m, b, 1, (it % 4 == 0) && (m != 8'h00));
      exp_done = 2 + k * (st ? 2 : 3) + waits;
      checks++;
      if (done_cyc != exp_done || done_cnt != 1) begin
        errors++;
        $display("FAIL rnd_done it=%0d: got cycle %0d count %0d, expected %0d and 1",
                 it, done_cyc, done_cnt, exp_done);
      end
      checks++;
      if (req_cycles != k + waits) begin
        errors++;
        $display("FAIL rnd_reqs it=%0d: got %0d request cycles, expected %0d", it, req_cycles, k + waits);
      end
      bad = (mw_q.size() != exp_mw.size()) || (rw_q.size() != exp_rw.size());
      if (!bad) begin
        foreach (exp_mw[j]) if (mw_q[j] !== exp_mw[j]) bad = 1;
        foreach (exp_rw[j]) if (rw_q[j] !== exp_rw[j]) bad = 1;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL rnd_data it=%0d: got %0d mem/%0d reg writes, expected %0d/%0d with matching data",
                 it, mw_q.size(), rw_q.size(), exp_mw.size(), exp_rw.size());
      end
      bad = (ra_q.size() != exp_ra.size());
      if (!bad) foreach (exp_ra[j]) if (ra_q[j] !== exp_ra[j]) bad = 1;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL rnd_reg_addr it=%0d: got %0d entries, expected %0d in ascending order",
                 it, ra_q.size(), exp_ra.size());
      end
      checks++;
      if (busy_after !== 1'b0) begin
        errors++; $display("FAIL rnd_busy it=%0d: got busy=%b after done, expected 0", it, busy_after);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) regs[i] = '0;
    test_reset();
    test_sm_directed();
    test_lm_directed();
    test_wait_states();
    test_boundaries();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
